// File: rtl/ctrl_pipe_stage_pkg.sv
// Shared definitions for pipeline stage registers: occupancy width and
// the saturating increment used by the performance counters.
package pipe_pkg;

  localparam int OCC_W = 2;

  // Adds step to value and clamps at 2^cw-1 (cw up to 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [1:0]  step,
                                          input int          cw);
    logic [32:0] sum;
    logic [32:0] max;
    max = (33'd1 << cw) - 33'd1;
    sum = {1'b0, value} + {31'd0, step};
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage_if.sv
// Valid/ready payload bundle between two pipeline stages.
// A beat transfers on a side exactly in a cycle where its valid and ready are both 1;
// valid never waits on ready, and a presented beat stays stable until it transfers.
interface ctrl_pipe_stage_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ctrl_pipe_stage_sat_counter.sv
// Saturating event counter with synchronous clear and a 0..3 step.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          inc_en,
  input  logic [1:0]    step,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc_en) begin
      count <= CW'(sat_inc(32'(count), step, CW));
    end
  end

endmodule

// File: rtl/ctrl_pipe_stage.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer, flush to bubble, and saturating stall / flush-drop counters.
module ctrl_pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter bit               SKID   = 1'b1,
  parameter int               CW     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  ctrl_pipe_stage_if.slave  bus,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CW-1:0]     stall_cnt,
  output logic [CW-1:0]     drop_cnt
);

  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             s_valid;
  logic             in_fire;
  logic             out_fire;
  logic [1:0]       drop_step;

  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = m_valid && bus.out_ready;
  assign bus.out_valid = m_valid;
  assign bus.out_data  = m_valid ? m_data : BUBBLE;
  assign occupancy     = OCC_W'(m_valid) + OCC_W'(s_valid);

  generate
    if (SKID) begin : g_skid
      logic [WIDTH-1:0] s_data;

      // in_ready comes only from registered state, so out_ready never reaches it.
      assign bus.in_ready = !reset && !s_valid && !flush;

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          m_valid <= 1'b0;
          s_valid <= 1'b0;
        end else if (!m_valid || bus.out_ready) begin
          if (s_valid) begin
            m_data  <= s_data;
            s_valid <= 1'b0;
          end else begin
            m_valid <= in_fire;
            if (in_fire) m_data <= bus.in_data;
          end
        end else if (in_fire) begin
          s_valid <= 1'b1;
          s_data  <= bus.in_data;
        end
      end
    end else begin : g_single
      assign s_valid      = 1'b0;
      assign bus.in_ready = !reset && (!m_valid || bus.out_ready) && !flush;

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          m_valid <= 1'b0;
        end else if (in_fire) begin
          m_valid <= 1'b1;
          m_data  <= bus.in_data;
        end else if (out_fire) begin
          m_valid <= 1'b0;
        end
      end
    end
  endgenerate

  // An entry leaving through the output in the flush cycle is not a drop.
  assign drop_step = occupancy - OCC_W'(out_fire);

  sat_counter #(.CW(CW)) u_stall_cnt (
    .clk    (clk),
    .clear  (reset),
    .inc_en (m_valid && !bus.out_ready),
    .step   (2'd1),
    .count  (stall_cnt)
  );

  sat_counter #(.CW(CW)) u_drop_cnt (
    .clk    (clk),
    .clear  (reset),
    .inc_en (flush && (drop_step != 2'd0)),
    .step   (drop_step),
    .count  (drop_cnt)
  );

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Bench for ctrl_pipe_stage: a skid instance (SKID=1, CW=16) and a single-entry
// instance (SKID=0, CW=2) checked against a FIFO model every cycle plus directed literals.
module tb_ctrl_pipe_stage;

  localparam logic [7:0] BUB_A = 8'h00;
  localparam logic [7:0] BUB_B = 8'hEE;

  logic        clk;
  logic        reset;
  logic        flush_a;
  logic        flush_b;
  logic [1:0]  occ_a;
  logic [1:0]  occ_b;
  logic [15:0] stall_a;
  logic [15:0] drop_a;
  logic [1:0]  stall_b;
  logic [1:0]  drop_b;

  int checks   = 0;
  int failures = 0;
  int n_out;

  ctrl_pipe_stage_if #(.WIDTH(8)) bus_a ();
  ctrl_pipe_stage_if #(.WIDTH(8)) bus_b ();

  ctrl_pipe_stage #(.WIDTH(8), .BUBBLE(BUB_A), .SKID(1'b1), .CW(16)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_a),
    .bus       (bus_a),
    .occupancy (occ_a),
    .stall_cnt (stall_a),
    .drop_cnt  (drop_a)
  );

  ctrl_pipe_stage #(.WIDTH(8), .BUBBLE(BUB_B), .SKID(1'b0), .CW(2)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_b),
    .bus       (bus_b),
    .occupancy (occ_b),
    .stall_cnt (stall_b),
    .drop_cnt  (drop_b)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic cmp(input string name, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h want=%0h", name, d, act, exp);
    end
  endtask

  // Model: each stage is a FIFO of capacity 2 (skid) or 1 (single) plus two counters.
  logic [7:0] md [2][2];
  int         mn  [2];
  int         ms  [2];
  int         mdp [2];
  bit         model_ok = 1'b0;

  function automatic int sat(input int v, input int d);
    int mx;
    mx = (d == 0) ? 65535 : 3;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_dut(input int d, input logic ov, input logic [7:0] od,
                           input logic ir, input logic [1:0] occ,
                           input logic [15:0] sc, input logic [15:0] dc,
                           input logic iv, input logic [7:0] idt,
                           input logic ordy, input logic fl);
    logic exp_ir;
    bit   ofire;
    bit   ifire;
    exp_ir = !reset && !fl && ((d == 0) ? (mn[d] < 2) : (mn[d] == 0 || ordy));
    if (model_ok) begin
      cmp("out_valid", d, ov, mn[d] > 0);
      cmp("out_data", d, od, (mn[d] > 0) ? md[d][0] : ((d == 0) ? BUB_A : BUB_B));
      cmp("in_ready", d, ir, exp_ir);
      cmp("occupancy", d, occ, mn[d]);
      cmp("stall_cnt", d, sc, ms[d]);
      cmp("drop_cnt", d, dc, mdp[d]);
      cmp("occ_le2", d, occ <= 2'd2, 1);
      cmp("held_implies_valid", d, (occ == 2'd0) || ov, 1);
    end
    if (reset) begin
      mn[d] = 0; ms[d] = 0; mdp[d] = 0;
    end else if (model_ok) begin
      ofire = (mn[d] > 0) && ordy;
      ifire = iv && exp_ir;
      if (mn[d] > 0 && !ordy) ms[d] = sat(ms[d] + 1, d);
      if (fl) begin
        mdp[d] = sat(mdp[d] + mn[d] - int'(ofire), d);
        mn[d] = 0;
      end else begin
        if (ofire) begin md[d][0] = md[d][1]; mn[d]--; end
        if (ifire) begin md[d][mn[d]] = idt; mn[d]++; end
      end
    end
  endtask

  always @(negedge clk) begin
    model_dut(0, bus_a.out_valid, bus_a.out_data, bus_a.in_ready, occ_a, stall_a, drop_a,
              bus_a.in_valid, bus_a.in_data, bus_a.out_ready, flush_a);
    model_dut(1, bus_b.out_valid, bus_b.out_data, bus_b.in_ready, occ_b,
              16'(stall_b), 16'(drop_b),
              bus_b.in_valid, bus_b.in_data, bus_b.out_ready, flush_b);
    if (reset) model_ok = 1'b1;
  end

  // ---------------- drivers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = 8'h00; bus_b.out_ready = 1'b0;
    neg();
    cmp("rst_in_ready", 0, bus_a.in_ready, 0);
    cmp("rst_in_ready", 1, bus_b.in_ready, 0);
    cyc(); reset = 1'b0;
    neg();
    cmp("rst_out_valid", 0, bus_a.out_valid, 0);
    cmp("rst_out_data", 0, bus_a.out_data, 8'h00);
    cmp("rst_occ", 0, occ_a, 0);
    cmp("rst_stall", 0, stall_a, 0);
    cmp("rst_drop", 0, drop_a, 0);
    cmp("post_rst_in_ready", 0, bus_a.in_ready, 1);
    cmp("rst_bubble", 1, bus_b.out_data, 8'hEE);

    // single push, 1-cycle latency
    cyc(); bus_a.in_valid = 1'b1; bus_a.in_data = 8'hA5; bus_a.out_ready = 1'b1;
    neg(); cmp("push_in_ready", 0, bus_a.in_ready, 1);
    cyc(); bus_a.in_valid = 1'b0;
    neg();
    cmp("push_valid", 0, bus_a.out_valid, 1);
    cmp("push_data", 0, bus_a.out_data, 8'hA5);
    cmp("push_occ1", 0, occ_a, 1);
    cyc(); neg();
    cmp("push_drained", 0, bus_a.out_valid, 0);
    cmp("push_occ0", 0, occ_a, 0);

    // backpressure into the skid register
    cyc(); bus_a.in_valid = 1'b1; bus_a.in_data = 8'hA1; bus_a.out_ready = 1'b0;
    neg();
    cyc(); bus_a.in_data = 8'hA2;
    neg(); cmp("bp_accept2", 0, bus_a.in_ready, 1);
    cyc(); bus_a.in_data = 8'hA3;
    neg();
    cmp("bp_full_ready", 0, bus_a.in_ready, 0);
    cmp("bp_occ2", 0, occ_a, 2);
    cmp("bp_head", 0, bus_a.out_data, 8'hA1);
    cyc(); neg(); cmp("bp_hold_ready", 0, bus_a.in_ready, 0);
    cyc(); bus_a.out_ready = 1'b1;
    neg();
    cmp("bp_out1", 0, bus_a.out_data, 8'hA1);
    cmp("bp_out1_ready", 0, bus_a.in_ready, 0);
    cyc(); neg();
    cmp("bp_out2", 0, bus_a.out_data, 8'hA2);
    cmp("bp_out2_ready", 0, bus_a.in_ready, 1);
    cyc(); bus_a.in_valid = 1'b0;
    neg();
    cmp("bp_out3", 0, bus_a.out_data, 8'hA3);
    cmp("bp_out3_valid", 0, bus_a.out_valid, 1);
    cmp("bp_stall", 0, stall_a, 3);
    cyc(); neg(); cmp("bp_empty", 0, bus_a.out_valid, 0);

    // streaming 100 beats
    n_out = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(); bus_a.in_valid = 1'b1; bus_a.in_data = 8'(i); bus_a.out_ready = 1'b1;
      neg();
      cmp("stream_in_ready", 0, bus_a.in_ready, 1);
      if (i > 0) cmp("stream_data", 0, bus_a.out_data, 8'(i - 1));
      if (bus_a.out_valid) n_out++;
    end
    cyc(); bus_a.in_valid = 1'b0;
    neg();
    cmp("stream_last", 0, bus_a.out_data, 8'd99);
    if (bus_a.out_valid) n_out++;
    cmp("stream_count", 0, n_out, 100);
    cmp("stream_no_stall", 0, stall_a, 3);
    cyc(); neg();

    // flush with two held entries and an input offered
    cyc(); bus_a.out_ready = 1'b0; bus_a.in_valid = 1'b1; bus_a.in_data = 8'hB1;
    neg();
    cyc(); bus_a.in_data = 8'hB2;
    neg();
    cyc(); flush_a = 1'b1; bus_a.in_data = 8'hB3;
    neg();
    cmp("flush_in_ready", 0, bus_a.in_ready, 0);
    cmp("flush_occ2", 0, occ_a, 2);
    cyc(); flush_a = 1'b0; bus_a.in_valid = 1'b0;
    neg();
    cmp("flush_valid", 0, bus_a.out_valid, 0);
    cmp("flush_bubble", 0, bus_a.out_data, 8'h00);
    cmp("flush_drop2", 0, drop_a, 2);
    cmp("flush_occ0", 0, occ_a, 0);
    cmp("flush_stall", 0, stall_a, 5);

    // flush while the only entry transfers out
    cyc(); bus_a.in_valid = 1'b1; bus_a.in_data = 8'hC1; bus_a.out_ready = 1'b1;
    neg();
    cyc(); bus_a.in_valid = 1'b0; flush_a = 1'b1;
    neg();
    cmp("flushx_valid", 0, bus_a.out_valid, 1);
    cmp("flushx_data", 0, bus_a.out_data, 8'hC1);
    cyc(); flush_a = 1'b0;
    neg();
    cmp("flushx_drop", 0, drop_a, 2);
    cmp("flushx_empty", 0, bus_a.out_valid, 0);
    cyc(); reset = 1'b1;
    neg();
    cyc(); reset = 1'b0;
    neg();
    cmp("rst2_stall", 0, stall_a, 0);
    cmp("rst2_drop", 0, drop_a, 0);
    cmp("rst2_valid", 0, bus_a.out_valid, 0);
    cmp("rst2_occ", 0, occ_a, 0);

    // single-entry stage: combinational ready and 2-bit saturation
    cyc(); bus_b.in_valid = 1'b1; bus_b.in_data = 8'hD1; bus_b.out_ready = 1'b0;
    neg(); cmp("b_empty_ready", 1, bus_b.in_ready, 1);
    cyc(); bus_b.in_data = 8'hD2;
    neg();
    cmp("b_full_ready", 1, bus_b.in_ready, 0);
    cmp("b_head", 1, bus_b.out_data, 8'hD1);
    cyc(); bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
    #1 cmp("b_comb_ready_hi", 1, bus_b.in_ready, 1);
    bus_b.out_ready = 1'b0;
    #1 cmp("b_comb_ready_lo", 1, bus_b.in_ready, 0);
    neg();
    for (int i = 0; i < 3; i++) begin
      cyc(); neg();
    end
    cmp("b_stall_sat", 1, stall_b, 3);
    cmp("b_still_head", 1, bus_b.out_data, 8'hD1);
    cyc(); flush_b = 1'b1;
    neg();
    cyc(); flush_b = 1'b0;
    neg();
    cmp("b_drop1", 1, drop_b, 1);
    cmp("b_flush_bubble", 1, bus_b.out_data, 8'hEE);
    cmp("b_stall_hold", 1, stall_b, 3);

    n_out = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(); bus_b.in_valid = 1'b1; bus_b.in_data = 8'h10 + 8'(i); bus_b.out_ready = 1'b1;
      neg();
      cmp("b_stream_ready", 1, bus_b.in_ready, 1);
      if (bus_b.out_valid) n_out++;
    end
    cyc(); bus_b.in_valid = 1'b0;
    neg();
    cmp("b_stream_last", 1, bus_b.out_data, 8'h17);
    if (bus_b.out_valid) n_out++;
    cmp("b_stream_count", 1, n_out, 8);

    cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_stage.md
Name: ctrl_pipe_stage

Overview:
- Parametrised pipeline stage register for control/data bundles between pipeline stages. Generalises the fixed 3-bit control latch.
- Adds a valid/ready handshake, an optional 2-entry skid buffer for full-throughput backpressure, and flush with a bubble value.
- Adds saturating stall and flush-drop counters for performance monitoring.
- Instantiated between stages (ID/EX, EX/MEM, MEM/WB) in place of per-stage hand-written latches.

Parameters:
- WIDTH, 8, width of the payload bundle in bits.
- BUBBLE, 0 (WIDTH bits), value driven on out_data whenever out_valid=0.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CW, 16, width of the performance counters.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- flush  input  1  discard all held entries; block input this cycle.
- in_valid  input  1  upstream presents a payload.
- in_ready  output  1  stage accepts the payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage presents a payload.
- out_ready  input  1  downstream accepts the payload this cycle.
- out_data  output  WIDTH  payload; equals BUBBLE when out_valid=0.
- occupancy  output  2  number of held entries (0..2; 0..1 when SKID=0).
- stall_cnt  output  CW  cycles with out_valid=1 and out_ready=0.
- drop_cnt  output  CW  entries discarded by flush.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high. Priority is reset > flush > normal operation.
- Reset values: out_valid=0, out_data=BUBBLE, occupancy=0, stall_cnt=0, drop_cnt=0. in_ready=0 during the reset cycle, 1 on the next cycle.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_data is sampled only on an input transfer.
  - out_data and out_valid hold stable while out_valid && !out_ready.
- Latency: 1 cycle from input transfer to out_valid when the stage is empty. Order is strict FIFO.
- SKID=1 storage: main register M (drives outputs) and skid register S.
  - in_ready = !S.valid && !flush. in_ready never depends combinationally on out_ready.
  - M empty: an accepted input loads M.
  - M full, out_ready=1, S full: S moves to M and S empties. No input is accepted because in_ready=0.
  - M full, out_ready=1, S empty: an accepted input loads M; with no input, M empties.
  - M full, out_ready=0, S empty: an accepted input loads S.
  - Sustained in_valid=out_ready=1 gives 1 transfer per cycle.
- SKID=0 storage: single register M. in_ready = (!M.valid || out_ready) && !flush. This is a combinational path out_ready -> in_ready. Throughput is 1 per cycle.
- Flush:
  - On the next edge all entries are cleared: out_valid=0, out_data=BUBBLE.
  - No input is accepted in the flush cycle, because in_ready is forced to 0.
  - An output transfer that completes in the flush cycle is not counted as dropped.
  - drop_cnt increases by the number of entries held and not transferred out that cycle (0, 1 or 2).
- Counters:
  - Both saturate at 2^CW-1 and do not wrap.
  - stall_cnt increments in every cycle with out_valid && !out_ready, including the flush cycle.
  - Both counters clear only on reset; flush does not clear them.
- Reset mid-operation: all held entries are discarded without counting; counters go to 0.
- Asserted protocol rules (bench checks):
  - occupancy never exceeds 2.
  - S.valid implies M.valid.

Decomposition:
- Shared package pipe_pkg: occupancy width constant (2) and a saturating-increment function sat_inc(value, step, CW).
- One natural sub-module: sat_counter (parameter CW; inputs inc_en, step[1:0]; synchronous clear), instantiated twice.
- Skid logic stays inline and is selected with a generate block on SKID.

Test Plan:
- Reset then single push (in_valid=1, in_data=8'hA5, out_ready=1) -> out_valid=1, out_data=A5 exactly 1 cycle later; occupancy 1 then 0.
- Backpressure, SKID=1: push A1, A2, A3 with out_ready=0 -> A1 in M, A2 in S, in_ready=0 after the second accept, A3 held upstream. Release out_ready -> output A1, A2, A3 in order; stall_cnt equals the number of out_ready=0 cycles while valid.
- Streaming: 100 consecutive pushes with out_ready=1 -> 100 outputs in 100 cycles after 1-cycle latency, no gaps, stall_cnt=0.
- Flush with occupancy=2 and out_ready=0, in_valid=1 -> next cycle out_valid=0, out_data=BUBBLE, drop_cnt=2. The input in the flush cycle is not accepted (in_ready=0).
- Flush with occupancy=1 and out_ready=1 -> the output transfers, drop_cnt unchanged. Reset after that -> all counters 0, out_valid=0.
- SKID=0, CW=2 -> in_ready follows out_ready combinationally when full. Hold out_ready=0 for 5 cycles -> stall_cnt saturates at 3.
